// File: rtl/oversampling_period_meter_if.sv
// Bundle between the iserdes transition detector and the period meter.
// The slave side is the meter; the master side is whoever feeds it and reads results.
`timescale 1ns/1ps
interface oversampling_period_meter_if #(
   parameter int CYCLE_BITS = 12
);
   localparam int TS_BITS = CYCLE_BITS + 6;

   logic               CHANGED_FLAG;
   logic [5:0]         CHANGED_BIT;
   logic [TS_BITS-1:0] HALF_PERIOD;
   logic [TS_BITS:0]   PERIOD;
   logic               HALF_VALID;
   logic               PERIOD_VALID;
   logic               NO_SIGNAL;

   modport master (
      output CHANGED_FLAG, CHANGED_BIT,
      input  HALF_PERIOD, PERIOD, HALF_VALID, PERIOD_VALID, NO_SIGNAL
   );

   modport slave (
      input  CHANGED_FLAG, CHANGED_BIT,
      output HALF_PERIOD, PERIOD, HALF_VALID, PERIOD_VALID, NO_SIGNAL
   );
endinterface

// File: rtl/oversampling_period_meter.sv
// Timestamps detector transitions in 1/64-cycle units and reports half and full
// periods between consecutive edges, with loss-of-signal detection.
`timescale 1ns/1ps
module oversampling_period_meter #(
   parameter int CYCLE_BITS     = 12,
   parameter int TIMEOUT_CYCLES = 2000
) (
   input logic                        CLK_PARALLEL,
   input logic                        RESET,
   oversampling_period_meter_if.slave meter
);
   localparam int TS_BITS = CYCLE_BITS + 6;
   localparam int TO_BITS = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT_CYCLES - 1);
   localparam logic [TO_BITS-1:0] TO_MAX  = TO_BITS'(TIMEOUT_CYCLES);

   // The modulo difference is only unambiguous if the timeout fires before the counter laps.
   generate
      if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (2 ** CYCLE_BITS) - 1) begin : g_bad_timeout
         $error("TIMEOUT_CYCLES must be in 1 .. 2**CYCLE_BITS-2");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FIRST = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   state_t               state_r;
   logic [CYCLE_BITS-1:0] cycle_cnt_r;
   logic [TO_BITS-1:0]   to_cnt_r;
   logic [TS_BITS-1:0]   last_ts_r;
   logic [TS_BITS-1:0]   prev_half_r;
   logic [TS_BITS-1:0]   half_period_r;
   logic [TS_BITS:0]     period_r;
   logic                 half_valid_r;
   logic                 period_valid_r;
   logic                 no_signal_r;

   logic [TS_BITS-1:0]   ts_s;
   logic [TS_BITS-1:0]   diff_s;
   logic [TS_BITS:0]     period_s;
   logic                 timeout_hit_s;

   // Timestamp of the current sample word and the interval arithmetic derived from it.
   always_comb begin
      ts_s          = {cycle_cnt_r, meter.CHANGED_BIT};
      diff_s        = ts_s - last_ts_r;
      period_s      = {1'b0, prev_half_r} + {1'b0, diff_s};
      timeout_hit_s = 1'b0;
      if (state_r != ST_IDLE && to_cnt_r == TO_LAST) begin
         timeout_hit_s = 1'b1;
      end else begin
         timeout_hit_s = 1'b0;
      end
   end

   // Cycle counter, measurement FSM, timeout and registered outputs.
   always_ff @(posedge CLK_PARALLEL or posedge RESET) begin
      if (RESET) begin
         state_r        <= ST_IDLE;
         cycle_cnt_r    <= '0;
         to_cnt_r       <= '0;
         last_ts_r      <= '0;
         prev_half_r    <= '0;
         half_period_r  <= '0;
         period_r       <= '0;
         half_valid_r   <= 1'b0;
         period_valid_r <= 1'b0;
         no_signal_r    <= 1'b1;
      end else begin
         cycle_cnt_r    <= cycle_cnt_r + CYCLE_BITS'(1);
         half_valid_r   <= 1'b0;
         period_valid_r <= 1'b0;
         if (meter.CHANGED_FLAG) begin
            // A flag always wins over a timeout landing in the same cycle.
            to_cnt_r  <= '0;
            last_ts_r <= ts_s;
            case (state_r)
               ST_IDLE: begin
                  state_r <= ST_FIRST;
               end
               ST_FIRST: begin
                  half_period_r <= diff_s;
                  prev_half_r   <= diff_s;
                  half_valid_r  <= 1'b1;
                  state_r       <= ST_RUN;
               end
               ST_RUN: begin
                  half_period_r  <= diff_s;
                  period_r       <= period_s;
                  prev_half_r    <= diff_s;
                  half_valid_r   <= 1'b1;
                  period_valid_r <= 1'b1;
                  no_signal_r    <= 1'b0;
                  state_r        <= ST_RUN;
               end
               default: begin
                  state_r <= ST_IDLE;
               end
            endcase
         end else begin
            if (state_r != ST_IDLE && to_cnt_r != TO_MAX) begin
               to_cnt_r <= to_cnt_r + TO_BITS'(1);
            end else begin
               to_cnt_r <= to_cnt_r;
            end
            if (timeout_hit_s) begin
               state_r     <= ST_IDLE;
               no_signal_r <= 1'b1;
            end else begin
               state_r <= state_r;
            end
         end
      end
   end

   assign meter.HALF_PERIOD  = half_period_r;
   assign meter.PERIOD       = period_r;
   assign meter.HALF_VALID   = half_valid_r;
   assign meter.PERIOD_VALID = period_valid_r;
   assign meter.NO_SIGNAL    = no_signal_r;
endmodule

// File: tb/tb_oversampling_period_meter.sv
// Directed scoreboard bench for oversampling_period_meter: edges, counter wrap,
// timeout, the timeout/flag race and asynchronous reset mid-run.
`timescale 1ns/1ps
module tb_oversampling_period_meter;
   localparam int CB = 12;
   localparam int TO = 2000;

   typedef struct {
      logic        pv;
      logic [17:0] hp;
      logic [18:0] p;
      logic        ns;
      longint      t;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] cyc;
   longint      t = 0;
   int          total = 0;
   int          bad = 0;
   exp_t        sb_q[$];

   oversampling_period_meter_if #(.CYCLE_BITS(CB)) bus ();

   oversampling_period_meter #(.CYCLE_BITS(CB), .TIMEOUT_CYCLES(TO)) dut (
      .CLK_PARALLEL (clk),
      .RESET        (rst),
      .meter        (bus.slave)
   );

   always #2.5 clk = ~clk;

   always @(posedge clk) t <= t + 1;

   // Expected value of the DUT cycle counter during the current cycle.
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 12'd0;
      else     cyc <= cyc + 12'd1;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at t=%0d", name, act, exp, t);
      end
   endtask

   task automatic wait_cyc(input int target);
      int guard = 0;
      while (cyc != 12'(target) && guard < 6000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 6000) begin
         total++;
         bad++;
         $display("FAIL wait_budget: counter %0d never reached %0d", cyc, target);
      end
   endtask

   // Drive one flag in the cycle whose counter equals target; queue the expected strobe.
   task automatic issue(input int target, input logic [5:0] b, input bit strobe,
                        input bit pv, input logic [17:0] hp, input logic [18:0] p, input bit ns);
      exp_t e;
      wait_cyc(target);
      bus.CHANGED_FLAG = 1'b1;
      bus.CHANGED_BIT  = b;
      if (strobe) begin
         e.pv = pv; e.hp = hp; e.p = p; e.ns = ns; e.t = t + 1;
         sb_q.push_back(e);
      end
      @(negedge clk);
      bus.CHANGED_FLAG = 1'b0;
      bus.CHANGED_BIT  = 6'h2A;
   endtask

   // Monitor: every strobe must match the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (bus.HALF_VALID === 1'b1 || bus.PERIOD_VALID === 1'b1) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_strobe: hv=%0b pv=%0b hp=%0d at t=%0d",
                     bus.HALF_VALID, bus.PERIOD_VALID, bus.HALF_PERIOD, t);
         end else begin
            e = sb_q.pop_front();
            check("strobe_latency", 64'(t), 64'(e.t));
            check("half_valid", 64'(bus.HALF_VALID), 64'd1);
            check("period_valid", 64'(bus.PERIOD_VALID), 64'(e.pv));
            check("half_period", 64'(bus.HALF_PERIOD), 64'(e.hp));
            check("period", 64'(bus.PERIOD), 64'(e.p));
            check("no_signal", 64'(bus.NO_SIGNAL), 64'(e.ns));
         end
      end
   end

   task automatic check_idle_outputs(input string tag);
      check({tag, "_hp"}, 64'(bus.HALF_PERIOD), 64'd0);
      check({tag, "_p"}, 64'(bus.PERIOD), 64'd0);
      check({tag, "_hv"}, 64'(bus.HALF_VALID), 64'd0);
      check({tag, "_pv"}, 64'(bus.PERIOD_VALID), 64'd0);
      check({tag, "_ns"}, 64'(bus.NO_SIGNAL), 64'd1);
   endtask

   initial begin
      bus.CHANGED_FLAG = 1'b0;
      bus.CHANGED_BIT  = 6'd0;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      rst = 1'b0;

      // No flags for a long stretch: still no signal, no strobes.
      repeat (5000) @(negedge clk);
      check_idle_outputs("quiet");

      // Three edges: ts 645, 1317, 1984.
      issue(10, 6'd5, 1'b0, 1'b0, 18'd0, 19'd0, 1'b1);
      issue(20, 6'd37, 1'b1, 1'b0, 18'd672, 19'd0, 1'b1);
      issue(31, 6'd0, 1'b1, 1'b1, 18'd667, 19'd1339, 1'b0);

      // Timeout: last flag in counter 31, NO_SIGNAL rises in counter 31+TO+1.
      wait_cyc(31 + TO);
      check("ns_before_timeout", 64'(bus.NO_SIGNAL), 64'd0);
      @(negedge clk);
      check("ns_after_timeout", 64'(bus.NO_SIGNAL), 64'd1);
      check("hp_hold", 64'(bus.HALF_PERIOD), 64'd667);
      check("p_hold", 64'(bus.PERIOD), 64'd1339);

      // Re-acquire across the counter wrap: ts 261820 -> 258 -> 640.
      issue(4090, 6'd60, 1'b0, 1'b0, 18'd0, 19'd0, 1'b1);
      issue(4, 6'd2, 1'b1, 1'b0, 18'd582, 19'd1339, 1'b1);
      issue(10, 6'd0, 1'b1, 1'b1, 18'd382, 19'd964, 1'b0);

      // Race: flag exactly TO cycles later is still a measurement.
      issue(10 + TO, 6'd7, 1'b1, 1'b1, 18'd128007, 19'd128389, 1'b0);

      // One cycle later than that, the timeout has fired and the flag only re-arms.
      wait_cyc(10 + 2 * TO);
      check("ns_race_hold", 64'(bus.NO_SIGNAL), 64'd0);
      @(negedge clk);
      check("ns_late_flag", 64'(bus.NO_SIGNAL), 64'd1);
      check("hp_late_hold", 64'(bus.HALF_PERIOD), 64'd128007);
      issue(11 + 2 * TO, 6'd0, 1'b0, 1'b0, 18'd0, 19'd0, 1'b1);
      issue(15 + 2 * TO, 6'd1, 1'b1, 1'b0, 18'd257, 19'd128389, 1'b1);
      issue(20 + 2 * TO, 6'd0, 1'b1, 1'b1, 18'd319, 19'd576, 1'b0);

      // Asynchronous reset in the middle of a cycle clears everything at once.
      @(negedge clk);
      #1 rst = 1'b1;
      #0.5;
      check_idle_outputs("async_rst");
      @(negedge clk);
      rst = 1'b0;

      // Fresh start: counter restarted, first flag after reset gives no strobe.
      issue(3, 6'd1, 1'b0, 1'b0, 18'd0, 19'd0, 1'b1);
      issue(5, 6'd0, 1'b1, 1'b0, 18'd127, 19'd0, 1'b1);
      issue(6, 6'd0, 1'b1, 1'b1, 18'd64, 19'd191, 1'b0);

      repeat (4) @(negedge clk);
      check("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/oversampling_period_meter.md
Name: oversampling_period_meter

Overview:
- Sits directly downstream of oversampling_iserdes_detector in the theremin sensor chain, in the 200 MHz CLK_PARALLEL domain.
- Converts each CHANGED_FLAG/CHANGED_BIT event into an absolute timestamp in 1/64-cycle sample units (12.8 GS/s equivalent at 200 MHz).
- Measures the interval between consecutive input transitions (half period) and the sum of the last two (full period).
- Flags loss of signal when transitions stop.

Parameters:
- CYCLE_BITS, 12: width of the free-running CLK_PARALLEL cycle counter. Timestamp width TS_BITS = CYCLE_BITS+6.
- TIMEOUT_CYCLES, 2000: number of edge-free CLK_PARALLEL cycles after which NO_SIGNAL asserts. Must be < 2**CYCLE_BITS - 1 (elaboration-time assertion).

Ports:
- CLK_PARALLEL  in  1  200 MHz clock; the only clock.
- RESET  in  1  reset, asynchronous, active-high.
- CHANGED_FLAG  in  1  detector strobe: one transition in this cycle's 64-sample word.
- CHANGED_BIT  in  6  sample index of the transition; 0 = earliest sample, 63 = latest.
- HALF_PERIOD  out  TS_BITS  samples between the last two transitions.
- PERIOD  out  TS_BITS+1  sum of the last two half periods.
- HALF_VALID  out  1  one-cycle strobe: HALF_PERIOD updated.
- PERIOD_VALID  out  1  one-cycle strobe: PERIOD updated.
- NO_SIGNAL  out  1  high while no valid period is available.

Behaviour:
- Reset values: cycle counter=0, state=IDLE, timeout counter=0, HALF_PERIOD=0, PERIOD=0, HALF_VALID=0, PERIOD_VALID=0, NO_SIGNAL=1. Reset asserted mid-operation clears everything immediately; no partial measurement survives.
- Cycle counter: free-running, CYCLE_BITS wide, wraps 2**CYCLE_BITS-1 -> 0.
- Timestamp: ts = {cycle_counter, CHANGED_BIT}, TS_BITS wide. It is sampled in the same cycle as CHANGED_FLAG.
- Half-period arithmetic: diff = ts - last_ts modulo 2**TS_BITS, so counter wrap is transparent. The timeout guarantees diff < 2**TS_BITS.
- PERIOD = prev_half + diff, computed at TS_BITS+1 width with no truncation.
- Latency: CHANGED_FLAG in cycle N produces its registered outputs and strobes in cycle N+1. Strobes are high for exactly one cycle.
- State machine, advanced only on CHANGED_FLAG unless noted:
  - IDLE: store last_ts; go to FIRST. No strobes.
  - FIRST: HALF_PERIOD=diff, HALF_VALID=1, store prev_half=diff and last_ts; go to RUN. No PERIOD_VALID.
  - RUN: HALF_PERIOD=diff, PERIOD=prev_half+diff, HALF_VALID=1, PERIOD_VALID=1, NO_SIGNAL=0; update prev_half and last_ts; stay in RUN.
- Timeout counter:
  - Cleared to 0 on every CHANGED_FLAG.
  - Otherwise increments, saturating, while state != IDLE.
  - When it reaches TIMEOUT_CYCLES with no flag in that cycle: state -> IDLE, NO_SIGNAL=1 from the next cycle.
  - HALF_PERIOD and PERIOD hold their last values after timeout.
- Boundary: a flag arriving in the same cycle the timeout would fire wins. It is processed normally and the timeout does not fire.
- Boundary: for an edge in cycle N, a flag in cycle N+TIMEOUT_CYCLES is still a valid measurement.
- Boundary: CHANGED_BIT is ignored when CHANGED_FLAG=0.
- Boundary: diff=0 (two flags with identical timestamp) cannot occur from the detector. If it does, it is reported as 0 without special handling.
- After timeout, a new measurement requires three transitions again (IDLE->FIRST->RUN). NO_SIGNAL deasserts with the first PERIOD_VALID.

Test Plan:
1. Reset release, no flags for 5000 cycles -> NO_SIGNAL=1, no strobes, HALF_PERIOD=PERIOD=0.
2. Flags at counter 10/bit 5, 20/bit 37, 31/bit 0:
   - ts = 645, 1317, 1984.
   - After the 2nd flag: HALF_PERIOD=672, HALF_VALID only.
   - After the 3rd flag: HALF_PERIOD=667, PERIOD=1339, PERIOD_VALID=1, NO_SIGNAL=0.
   - Each output appears one cycle after its flag.
3. Wrap: flag at counter 4090/bit 60 (ts=261820), then counter 4/bit 2 (ts=258) -> HALF_PERIOD=582, no glitch.
4. Timeout: in RUN, stop flags.
   - NO_SIGNAL rises exactly TIMEOUT_CYCLES+1 cycles after the last flag; outputs hold.
   - Next flag gives no strobe; the 2nd flag after that gives HALF_VALID only; the 3rd gives PERIOD_VALID.
5. Race: flag exactly TIMEOUT_CYCLES cycles after the previous flag -> accepted, HALF_PERIOD=TIMEOUT_CYCLES*64 + bit delta, NO_SIGNAL stays 0.
6. Full chain with iserdes+detector, 800 MHz shift clock, FREQ_IN 2145.23 ns halves -> HALF_PERIOD within ±1 of 27459 samples (2145.23 ns × 12.8 GS/s); reset pulsed mid-run clears all outputs asynchronously.
